// File: rtl/gpio_led_sched_if.sv
// Signal bundle between the LED requesters (master side) and gpio_led_sched (slave side).
interface gpio_led_sched_if #(
    parameter int pReqNum = 4
);
    logic                 iEnable;
    logic [pReqNum-1:0]   iReq;
    logic [pReqNum*8-1:0] iReqLed;
    logic [pReqNum*8-1:0] iReqDiv;
    logic [7:0]           iIdleLed;
    logic [7:0]           iIdleDiv;
    logic [pReqNum-1:0]   oGnt;
    logic [pReqNum-1:0]   oDone;
    logic                 oBusy;
    logic [7:0]           oGpioLed;
    logic [7:0]           oGpioDiv;

    modport master (
        output iEnable, iReq, iReqLed, iReqDiv, iIdleLed, iIdleDiv,
        input  oGnt, oDone, oBusy, oGpioLed, oGpioDiv
    );

    modport slave (
        input  iEnable, iReq, iReqLed, iReqDiv, iIdleLed, iIdleDiv,
        output oGnt, oDone, oBusy, oGpioLed, oGpioDiv
    );
endinterface

// File: rtl/gpio_led_sched.sv
// Round-robin time-slice scheduler for the LED pattern / shift divider of the GPIO LED unit.
// Optional macro GPIO_SCHED_PRIO_EN: requester 0 pre-empts any other requester's HOLD.
//
// state   | meaning
// IDLE    | no grant, LED unit fed from idle values
// ARB     | pick first requester after the pointer, latch its data
// HOLD    | grant active for the hold window
// RELEASE | done pulse on the granted bit, pointer moves to it
module gpio_led_sched #(
    parameter int         pReqNum     = 4,
    parameter int         pHoldCntBit = 24,
    parameter int         pHoldCycles = 'd1000000,
    parameter logic [7:0] pDivReset   = 8'h10
) (
    input logic             iSysClk,
    input logic             iSysRst,
    gpio_led_sched_if.slave bus
);
    localparam int lIdxW = (pReqNum > 1) ? $clog2(pReqNum) : 1;
    localparam int lHold = (pHoldCycles < 1) ? 1 : pHoldCycles;
    localparam logic [pHoldCntBit-1:0] lHoldLast = pHoldCntBit'(lHold - 1);

    typedef enum logic [1:0] {sIdle, sArb, sHold, sRelease} tState;

    tState                  state, stateNext;
    logic [pReqNum-1:0]     gnt, gntNext, done, doneNext;
    logic                   busy;
    logic [7:0]             gpioLed, gpioLedNext, gpioDiv, gpioDivNext;
    logic [pHoldCntBit-1:0] holdCnt, holdCntNext;
    logic [lIdxW-1:0]       ptr, ptrNext, gntIdx, gntIdxNext;

    logic                   selFound;
    logic [lIdxW-1:0]       selIdx, cand, dataIdx;
    logic [pReqNum-1:0]     selOneHot;
    logic [7:0]             reqLed, reqDiv;
    logic                   holdEnd, extend, preempt, forceZero;

`ifdef GPIO_SCHED_PRIO_EN
    logic urgent;

    assign preempt   = (state == sHold) && bus.iReq[0] && (gntIdx != '0);
    assign forceZero = urgent && bus.iReq[0];

    // Remembers that the coming ARB is the urgent one, so it bypasses the pointer.
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst)                            urgent <= 1'b0;
        else if (!bus.iEnable || state == sArb) urgent <= 1'b0;
        else if (preempt)                       urgent <= 1'b1;
    end
`else
    assign preempt   = 1'b0;
    assign forceZero = 1'b0;
`endif

    // Descending scan so the candidate closest after the pointer wins.
    always_comb begin
        selFound = 1'b0;
        selIdx   = '0;
        cand     = '0;
        for (int k = pReqNum; k >= 1; k--) begin
            cand = lIdxW'((int'(ptr) + k) % pReqNum);
            if (bus.iReq[cand]) begin
                selFound = 1'b1;
                selIdx   = cand;
            end
        end
        if (forceZero) begin
            selFound = 1'b1;
            selIdx   = '0;
        end
    end

    always_comb begin
        selOneHot         = '0;
        selOneHot[selIdx] = 1'b1;
    end

    assign dataIdx = (state == sArb) ? selIdx : gntIdx;
    assign reqLed  = bus.iReqLed[{dataIdx, 3'b000} +: 8];
    assign reqDiv  = bus.iReqDiv[{dataIdx, 3'b000} +: 8];
    assign holdEnd = (holdCnt == lHoldLast);
    assign extend  = bus.iReq[gntIdx] && ((bus.iReq & ~gnt) == '0);

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            state   <= sIdle;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            gpioLed <= 8'h00;
            gpioDiv <= pDivReset;
            holdCnt <= '0;
            ptr     <= lIdxW'(pReqNum - 1);
            gntIdx  <= '0;
        end else begin
            state   <= stateNext;
            gnt     <= gntNext;
            done    <= doneNext;
            busy    <= (stateNext != sIdle);
            gpioLed <= gpioLedNext;
            gpioDiv <= gpioDivNext;
            holdCnt <= holdCntNext;
            ptr     <= ptrNext;
            gntIdx  <= gntIdxNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (!bus.iEnable) begin
            stateNext = sIdle;
        end else begin
            case (state)
                sIdle:    if (|bus.iReq) stateNext = sArb;
                sArb:     stateNext = selFound ? sHold : sIdle;
                sHold: begin
                    if (preempt)                stateNext = sArb;
                    else if (holdEnd && !extend) stateNext = sRelease;
                end
                sRelease: stateNext = (|bus.iReq) ? sArb : sIdle;
                default:  stateNext = sIdle;
            endcase
        end
    end

    always_comb begin
        gntNext     = gnt;
        doneNext    = '0;
        gpioLedNext = gpioLed;
        gpioDivNext = gpioDiv;
        holdCntNext = holdCnt;
        ptrNext     = ptr;
        gntIdxNext  = gntIdx;
        if (!bus.iEnable) begin
            gntNext     = '0;
            gpioLedNext = bus.iIdleLed;
            gpioDivNext = bus.iIdleDiv;
            holdCntNext = '0;
        end else begin
            case (state)
                sIdle: begin
                    gntNext     = '0;
                    gpioLedNext = bus.iIdleLed;
                    gpioDivNext = bus.iIdleDiv;
                end
                sArb: begin
                    if (selFound) begin
                        gntNext     = selOneHot;
                        gntIdxNext  = selIdx;
                        gpioLedNext = reqLed;
                        gpioDivNext = reqDiv;
                        holdCntNext = '0;
                    end else begin
                        gntNext     = '0;
                        gpioLedNext = bus.iIdleLed;
                        gpioDivNext = bus.iIdleDiv;
                    end
                end
                sHold: begin
                    if (preempt) begin
                        gntNext     = '0;
                        holdCntNext = '0;
                    end else if (holdEnd) begin
                        if (extend) begin
                            holdCntNext = '0;
                            gpioLedNext = reqLed;
                            gpioDivNext = reqDiv;
                        end else begin
                            gntNext  = '0;
                            doneNext = gnt;
                            ptrNext  = gntIdx;
                        end
                    end else begin
                        holdCntNext = holdCnt + pHoldCntBit'(1);
                    end
                end
                default: gntNext = '0;
            endcase
        end
    end

    assign bus.oGnt     = gnt;
    assign bus.oDone    = done;
    assign bus.oBusy    = busy;
    assign bus.oGpioLed = gpioLed;
    assign bus.oGpioDiv = gpioDiv;
endmodule

// File: tb/tb_gpio_led_sched.sv
// Directed bench for gpio_led_sched (pHoldCycles=4); expected outputs are cycle-stamped in a
// scoreboard queue and compared on the falling edge of the matching cycle.
module tb_gpio_led_sched;
    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] gnt;
        logic [3:0] done;
        logic       busy;
        logic [7:0] led;
        logic [7:0] div;
    } tExp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         t0;
    tExp        sb[$];
    tExp        cur;
    logic [7:0] rrLed[4];
    logic [7:0] rrDiv[4];

    gpio_led_sched_if #(.pReqNum(4)) bus ();

    gpio_led_sched #(
        .pReqNum    (4),
        .pHoldCntBit(8),
        .pHoldCycles(4),
        .pDivReset  (8'h10)
    ) dut (
        .iSysClk(clk),
        .iSysRst(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    function automatic void pushExp(input int c, input string tag, input logic [3:0] g,
                                    input logic [3:0] d, input logic b, input logic [7:0] l,
                                    input logic [7:0] v);
        tExp e;
        int  pos;
        e.cyc  = c;
        e.tag  = tag;
        e.gnt  = g;
        e.done = d;
        e.busy = b;
        e.led  = l;
        e.div  = v;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].cyc > c) pos--;
        sb.insert(pos, e);
    endfunction

    task automatic tickTo(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            checks++;
            assert (cur.cyc == cyc && bus.oGnt === cur.gnt && bus.oDone === cur.done &&
                    bus.oBusy === cur.busy && bus.oGpioLed === cur.led && bus.oGpioDiv === cur.div)
            else begin
                errors++;
                $error("FAIL %s @cyc %0d: got gnt=%b done=%b busy=%b led=%h div=%h, want cyc %0d gnt=%b done=%b busy=%b led=%h div=%h",
                       cur.tag, cyc, bus.oGnt, bus.oDone, bus.oBusy, bus.oGpioLed, bus.oGpioDiv,
                       cur.cyc, cur.gnt, cur.done, cur.busy, cur.led, cur.div);
            end
        end
    end

    initial begin
        rrLed = '{8'h3C, 8'hC1, 8'hC2, 8'hC3};
        rrDiv = '{8'h40, 8'h41, 8'h42, 8'h43};
        bus.iEnable  = 1'b0;
        bus.iReq     = 4'b0000;
        bus.iReqLed  = {8'hC3, 8'hC2, 8'hC1, 8'h3C};
        bus.iReqDiv  = {8'h43, 8'h42, 8'h41, 8'h40};
        bus.iIdleLed = 8'hA5;
        bus.iIdleDiv = 8'h20;

        // Reset held through edge 3; idle values appear one edge after release.
        for (int c = 1; c <= 3; c++) pushExp(c, "reset", 4'b0, 4'b0, 1'b0, 8'h00, 8'h10);
        pushExp(4, "idle_after_rst", 4'b0, 4'b0, 1'b0, 8'hA5, 8'h20);
        pushExp(5, "idle_after_rst", 4'b0, 4'b0, 1'b0, 8'hA5, 8'h20);
        tickTo(3);
        rst = 1'b0;
        tickTo(6);

`ifndef GPIO_SCHED_PRIO_EN
        // All four requesting: 0,1,2,3,0 with 4-cycle grants and 2-cycle gaps.
        t0 = cyc;
        bus.iEnable = 1'b1;
        bus.iReq    = 4'b1111;
        pushExp(t0 + 1, "rr_arb", 4'b0, 4'b0, 1'b1, 8'hA5, 8'h20);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++)
                pushExp(t0 + 2 + 6*k + j, "rr_gnt", oh(k % 4), 4'b0, 1'b1, rrLed[k % 4], rrDiv[k % 4]);
            pushExp(t0 + 6 + 6*k, "rr_done", 4'b0, oh(k % 4), 1'b1, rrLed[k % 4], rrDiv[k % 4]);
            pushExp(t0 + 7 + 6*k, "rr_gap", 4'b0, 4'b0, (k < 4), rrLed[k % 4], rrDiv[k % 4]);
        end
        tickTo(t0 + 26);
        bus.iReq = 4'b0000;
        tickTo(t0 + 32);
`endif

        // Single requester: extension every 4 cycles, new data only at the boundary.
        t0 = cyc;
        bus.iEnable = 1'b1;
        bus.iReq    = 4'b0001;
        pushExp(t0 + 1, "single_arb", 4'b0, 4'b0, 1'b1, 8'hA5, 8'h20);
        for (int j = 2; j <= 21; j++)
            pushExp(t0 + j, "single_hold", 4'b0001, 4'b0, 1'b1, (j < 6) ? 8'h3C : 8'h55, 8'h40);
        pushExp(t0 + 22, "single_done", 4'b0, 4'b0001, 1'b1, 8'h55, 8'h40);
        pushExp(t0 + 23, "single_idle", 4'b0, 4'b0, 1'b0, 8'h55, 8'h40);
        tickTo(t0 + 2);
        bus.iReqLed[7:0] = 8'h55;
        tickTo(t0 + 21);
        bus.iReq = 4'b0000;
        tickTo(t0 + 24);

`ifndef GPIO_SCHED_PRIO_EN
        // Disable mid-HOLD of requester 1; pointer must stay so 1 beats 0 on re-enable.
        t0 = cyc;
        bus.iReq = 4'b0010;
        pushExp(t0 + 1, "dis_arb", 4'b0, 4'b0, 1'b1, 8'hA5, 8'h20);
        pushExp(t0 + 2, "dis_gnt", 4'b0010, 4'b0, 1'b1, 8'hC1, 8'h41);
        pushExp(t0 + 3, "dis_gnt", 4'b0010, 4'b0, 1'b1, 8'hC1, 8'h41);
        for (int j = 4; j <= 6; j++)
            pushExp(t0 + j, "dis_off", 4'b0, 4'b0, 1'b0, 8'hA5, 8'h20);
        pushExp(t0 + 7, "reen_arb", 4'b0, 4'b0, 1'b1, 8'hA5, 8'h20);
        for (int j = 8; j <= 11; j++)
            pushExp(t0 + j, "reen_gnt1", 4'b0010, 4'b0, 1'b1, 8'hC1, 8'h41);
        pushExp(t0 + 12, "reen_done1", 4'b0, 4'b0010, 1'b1, 8'hC1, 8'h41);
        pushExp(t0 + 13, "reen_gap", 4'b0, 4'b0, 1'b1, 8'hC1, 8'h41);
        for (int j = 14; j <= 17; j++)
            pushExp(t0 + j, "reen_gnt0", 4'b0001, 4'b0, 1'b1, 8'h55, 8'h40);
        pushExp(t0 + 18, "reen_done0", 4'b0, 4'b0001, 1'b1, 8'h55, 8'h40);
        pushExp(t0 + 19, "reen_idle", 4'b0, 4'b0, 1'b0, 8'h55, 8'h40);
        tickTo(t0 + 3);
        bus.iEnable = 1'b0;
        tickTo(t0 + 6);
        bus.iEnable = 1'b1;
        bus.iReq    = 4'b0011;
        tickTo(t0 + 14);
        bus.iReq = 4'b0000;
        tickTo(t0 + 20);
`endif

        // Requester 2 drops its request one cycle into HOLD; window still 4 cycles.
        t0 = cyc;
        bus.iReq = 4'b0100;
        pushExp(t0 + 1, "drop_arb", 4'b0, 4'b0, 1'b1, 8'hA5, 8'h20);
        for (int j = 2; j <= 5; j++)
            pushExp(t0 + j, "drop_gnt", 4'b0100, 4'b0, 1'b1, 8'hC2, 8'h42);
        pushExp(t0 + 6, "drop_done", 4'b0, 4'b0100, 1'b1, 8'hC2, 8'h42);
        pushExp(t0 + 7, "drop_idle", 4'b0, 4'b0, 1'b0, 8'hC2, 8'h42);
        tickTo(t0 + 3);
        bus.iReq = 4'b0000;
        tickTo(t0 + 8);

`ifdef GPIO_SCHED_PRIO_EN
        // Requester 0 pre-empts requester 2, then 2 is served right after 0 releases.
        t0 = cyc;
        bus.iReq = 4'b0100;
        pushExp(t0 + 1, "prio_arb", 4'b0, 4'b0, 1'b1, 8'hA5, 8'h20);
        pushExp(t0 + 2, "prio_gnt2", 4'b0100, 4'b0, 1'b1, 8'hC2, 8'h42);
        pushExp(t0 + 3, "prio_abort", 4'b0, 4'b0, 1'b1, 8'hC2, 8'h42);
        for (int j = 4; j <= 7; j++)
            pushExp(t0 + j, "prio_gnt0", 4'b0001, 4'b0, 1'b1, 8'h55, 8'h40);
        pushExp(t0 + 8, "prio_done0", 4'b0, 4'b0001, 1'b1, 8'h55, 8'h40);
        pushExp(t0 + 9, "prio_gap", 4'b0, 4'b0, 1'b1, 8'h55, 8'h40);
        for (int j = 10; j <= 13; j++)
            pushExp(t0 + j, "prio_regnt2", 4'b0100, 4'b0, 1'b1, 8'hC2, 8'h42);
        pushExp(t0 + 14, "prio_done2", 4'b0, 4'b0100, 1'b1, 8'hC2, 8'h42);
        pushExp(t0 + 15, "prio_idle", 4'b0, 4'b0, 1'b0, 8'hC2, 8'h42);
        tickTo(t0 + 2);
        bus.iReq = 4'b0101;
        tickTo(t0 + 4);
        bus.iReq = 4'b0100;
        tickTo(t0 + 10);
        bus.iReq = 4'b0000;
        tickTo(t0 + 16);
`endif

        tickTo(cyc + 2);
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_drain: %0d expectations never compared, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
